// File: rtl/riv_ripple_timer_pkg.sv
// Shared types and helpers for the ripple-digit down timer.
package riv_ripple_timer_pkg;

    typedef enum logic {
        MODE_ONESHOT  = 1'b0,
        MODE_PERIODIC = 1'b1
    } mode_t;

    localparam int RIV_TIMER_DEF_PRIM_WIDTH = 4;

    function automatic int n_dig(input int width, input int prim_width);
        return (width + prim_width - 1) / prim_width;
    endfunction

endpackage

// File: rtl/riv_ripple_timer_digit.sv
// One down-counting digit with load, borrow-enable and wrap to all-ones.
// RIV_RIPPLE_TIMER_LOOKAHEAD_EN makes is_zero a registered flag.
module riv_ripple_timer_digit
    import riv_ripple_timer_pkg::*;
#(
    parameter int PRIM_WIDTH = RIV_TIMER_DEF_PRIM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [PRIM_WIDTH-1:0] load_val,
    input  logic                  dec,
    output logic [PRIM_WIDTH-1:0] val,
    output logic                  is_zero
);

    logic [PRIM_WIDTH-1:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (load) begin
            val_d = load_val;
        end else if (dec) begin
            val_d = val_q - PRIM_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            val_q <= '0;
        end else begin
            val_q <= val_d;
        end
    end

    assign val = val_q;

`ifdef RIV_RIPPLE_TIMER_LOOKAHEAD_EN
    logic zero_q, zero_d;

    // The flag predicts the zero state of val_d, so it tracks the digit cycle for cycle.
    always_comb begin
        zero_d = zero_q;
        if (load) begin
            zero_d = (load_val == '0);
        end else if (dec) begin
            zero_d = (val_q == PRIM_WIDTH'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign is_zero = zero_q;
`else
    assign is_zero = (val_q == '0);
`endif

endmodule

// File: rtl/riv_ripple_timer.sv
// Programmable one-shot/periodic down timer built from ripple-borrow digits.
// Optional build macro: RIV_RIPPLE_TIMER_LOOKAHEAD_EN (registered per-digit zero flags).
module riv_ripple_timer
    import riv_ripple_timer_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int PRIM_WIDTH = RIV_TIMER_DEF_PRIM_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] value,
    input  logic             load,
    input  logic             mode,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             done,
    output logic             expire,
    output logic             busy
);

    localparam int N_DIG = n_dig(WIDTH, PRIM_WIDTH);
    localparam int D0_W  = (WIDTH < PRIM_WIDTH) ? WIDTH : PRIM_WIDTH;

    logic [WIDTH-1:0] reload_q, reload_d;
    mode_t            mode_q, mode_d;
    logic             expire_q, expire_d;

    logic [N_DIG-1:0] dig_zero;
    logic [N_DIG-1:0] dig_dec;
    logic [WIDTH-1:0] load_src;
    logic             step, hi_zero, is_one, dig_load;

    always_comb begin
        hi_zero = 1'b1;
        for (int i = 1; i < N_DIG; i++) begin
            hi_zero = hi_zero & dig_zero[i];
        end
    end

    assign is_one   = hi_zero && (count[D0_W-1:0] == D0_W'(1));
    assign done     = &dig_zero;
    assign busy     = ~done;
    // A zero count never steps, so the digits cannot wrap past zero.
    assign step     = enable & ~load & ~done;
    assign dig_load = load | (step & is_one & (mode_q == MODE_PERIODIC));
    assign load_src = load ? value : reload_q;

    assign dig_dec[0] = step;
    for (genvar i = 1; i < N_DIG; i++) begin : g_borrow
        assign dig_dec[i] = dig_dec[i-1] & dig_zero[i-1];
    end

    // The top digit is trimmed to the bits that exist, so padding is never stored.
    for (genvar i = 0; i < N_DIG; i++) begin : g_dig
        localparam int LO = i * PRIM_WIDTH;
        localparam int DW = (WIDTH - LO < PRIM_WIDTH) ? (WIDTH - LO) : PRIM_WIDTH;
        riv_ripple_timer_digit #(.PRIM_WIDTH(DW)) u_digit (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (dig_load),
            .load_val (load_src[LO +: DW]),
            .dec      (dig_dec[i]),
            .val      (count[LO +: DW]),
            .is_zero  (dig_zero[i])
        );
    end

    always_comb begin
        reload_d = reload_q;
        mode_d   = mode_q;
        expire_d = step & is_one;
        if (load) begin
            reload_d = value;
            mode_d   = mode_t'(mode);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reload_q <= '0;
            mode_q   <= MODE_ONESHOT;
            expire_q <= 1'b0;
        end else begin
            reload_q <= reload_d;
            mode_q   <= mode_d;
            expire_q <= expire_d;
        end
    end

    assign expire = expire_q;

endmodule

// File: tb/tb_riv_ripple_timer.sv
// Directed self-checking bench for riv_ripple_timer (16/4 and 10/3 configurations).
module tb_riv_ripple_timer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load, mode, enable;
    logic [15:0] value16;
    logic [9:0]  value10;
    logic [15:0] count16;
    logic [9:0]  count10;
    logic        done16, expire16, busy16;
    logic        done10, expire10, busy10;

    int checks = 0;
    int errors = 0;

    riv_ripple_timer #(.WIDTH(16), .PRIM_WIDTH(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .value(value16), .load(load), .mode(mode),
        .enable(enable), .count(count16), .done(done16), .expire(expire16), .busy(busy16)
    );

    riv_ripple_timer #(.WIDTH(10), .PRIM_WIDTH(3)) dut10 (
        .clk(clk), .rst_n(rst_n), .value(value10), .load(load), .mode(mode),
        .enable(enable), .count(count10), .done(done10), .expire(expire10), .busy(busy10)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_idle16(input string tag);
        check({tag, "_count"},  64'(count16),  64'h0);
        check({tag, "_done"},   64'(done16),   64'h1);
        check({tag, "_busy"},   64'(busy16),   64'h0);
        check({tag, "_expire"}, 64'(expire16), 64'h0);
    endtask

    initial begin
        int pulses;
        logic [15:0] mcnt;
        logic        mexp;

        rst_n = 1'b0; load = 1'b0; mode = 1'b0; enable = 1'b0;
        value16 = '0; value10 = '0;
        @(negedge clk);
        tick();
        rst_n = 1'b1;

        // 1: reset/idle, then enable on zero count
        for (int i = 0; i < 10; i++) begin
            check_idle16("idle");
            tick();
        end
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle16("idle_en");
        end

        // 2: one-shot 0x12, borrow across digits, single expire
        mode = 1'b0; value16 = 16'h0012; load = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        check("os_load", 64'(count16), 64'h12);
        check("os_load_busy", 64'(busy16), 64'h1);
        for (int k = 1; k <= 18; k++) begin
            tick();
            check("os_count",  64'(count16),  64'(16'h0012 - 16'(k)));
            check("os_expire", 64'(expire16), 64'(k == 18));
            check("os_done",   64'(done16),   64'(k == 18));
        end
        tick();
        check("os_expire_after", 64'(expire16), 64'h0);
        check("os_hold", 64'(count16), 64'h0);

        // 3: periodic reload 5 for 20 enabled cycles, then reload 1
        mode = 1'b1; value16 = 16'd5; load = 1'b1;
        tick();
        load = 1'b0;
        check("per5_load", 64'(count16), 64'd5);
        pulses = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (expire16) pulses++;
            check("per5_count",  64'(count16),  64'((k % 5 == 0) ? 5 : 5 - (k % 5)));
            check("per5_expire", 64'(expire16), 64'(k % 5 == 0));
        end
        check("per5_pulses", 64'(pulses), 64'd4);
        value16 = 16'd1; load = 1'b1;
        tick();
        load = 1'b0;
        check("per1_load_expire", 64'(expire16), 64'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("per1_count",  64'(count16),  64'd1);
            check("per1_expire", 64'(expire16), 64'h1);
        end

        // 4: enable 1-of-3, one-shot load 3
        mode = 1'b0; value16 = 16'd3; load = 1'b1; enable = 1'b0;
        tick();
        load = 1'b0;
        check("gate_load", 64'(count16), 64'd3);
        mcnt = 16'd3;
        for (int j = 0; j < 9; j++) begin
            enable = (j % 3 == 0);
            mexp = 1'b0;
            if (enable && mcnt != 0) begin
                mexp = (mcnt == 16'd1);
                mcnt = mcnt - 16'd1;
            end
            tick();
            check("gate_count",  64'(count16),  64'(mcnt));
            check("gate_expire", 64'(expire16), 64'(mexp));
        end

        // 5: simultaneous load/enable, load 0, restart while busy
        mode = 1'b0; value16 = 16'd7; load = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        check("ld7_en", 64'(count16), 64'd7);
        for (int k = 0; k < 5; k++) tick();
        check("pre_reload", 64'(count16), 64'd2);
        value16 = 16'd9; load = 1'b1;
        tick();
        load = 1'b0;
        check("reload9_count",  64'(count16),  64'd9);
        check("reload9_expire", 64'(expire16), 64'h0);
        value16 = 16'd0; load = 1'b1;
        tick();
        load = 1'b0;
        check_idle16("ld0_os");
        tick();
        check_idle16("ld0_os_next");
        mode = 1'b1; load = 1'b1;
        tick();
        load = 1'b0;
        check_idle16("ld0_per");
        tick();
        check_idle16("ld0_per_next");

        // registered pulse survives a load applied in its cycle
        mode = 1'b0; value16 = 16'd1; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("term_expire", 64'(expire16), 64'h1);
        value16 = 16'd4; load = 1'b1;
        #1;
        check("term_expire_with_load", 64'(expire16), 64'h1);
        @(negedge clk);
        load = 1'b0;
        check("post_term_load_count",  64'(count16),  64'd4);
        check("post_term_load_expire", 64'(expire16), 64'h0);

        // 6: reset mid-count in both configurations
        mode = 1'b0; value16 = 16'hFFFF; value10 = 10'h3FF; load = 1'b1; enable = 1'b1;
        tick();
        load = 1'b0;
        for (int k = 0; k < 100; k++) tick();
        check("long16", 64'(count16), 64'hFF9B);
        check("long10", 64'(count10), 64'h39B);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        enable = 1'b0;
        check_idle16("rst16");
        check("rst10_count",  64'(count10),  64'h0);
        check("rst10_done",   64'(done10),   64'h1);
        check("rst10_expire", 64'(expire10), 64'h0);
        tick();
        check("rst16_no_expire", 64'(expire16), 64'h0);

        // 10/3 borrow across the trimmed top digit and one-shot terminal
        value10 = 10'h200; value16 = 16'h0; load = 1'b1;
        tick();
        load = 1'b0; enable = 1'b1;
        tick();
        check("w10_borrow", 64'(count10), 64'h1FF);
        value10 = 10'd2; load = 1'b1;
        tick();
        load = 1'b0;
        tick();
        check("w10_one", 64'(count10), 64'd1);
        tick();
        check("w10_zero",   64'(count10),  64'd0);
        check("w10_expire", 64'(expire10), 64'h1);
        tick();
        check("w10_hold",        64'(count10),  64'd0);
        check("w10_expire_done", 64'(expire10), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
